approx_dot_accumulator: RTL and testbench
=========================================

// Module: approx_dot_accumulator
// PURPOSE
//  Downstream consumer of the 8x8 unsigned approximate multipliers: accepts a stream of
//  16-bit products over a valid/ready handshake and sums a programmed number of them.
//  Emits one saturating dot-product result per job. Turns the purely combinational
//  multiplier into a usable MAC datapath for error-tolerant kernels.
// PARAMETERS
//  PROD_W  16  product width; must match multiplier output z
//  ACC_W   24  accumulator/result width; must be >= PROD_W
//  LEN_W   8   job length counter width; max job = 2**LEN_W-1 products
//  BIAS    0   per-product error-compensation constant, PROD_W bits; used only with the macro
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-high
//  cfg_start  in   1       start a job; sampled only in IDLE
//  cfg_len    in   LEN_W   number of products in the job
//  in_valid   in   1       product valid
//  in_ready   out  1       product accepted when in_valid & in_ready
//  in_prod    in   PROD_W  product, unsigned
//  out_valid  out  1       result valid
//  out_ready  in   1       result consumed when out_valid & out_ready
//  out_sum    out  ACC_W   accumulated sum, unsigned
//  out_sat    out  1       sticky: job saturated
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; acc=0, cnt=0, out_valid=0, out_sum=0, out_sat=0, in_ready=0, busy=0.
//  Reset mid-job: job is dropped and no result is produced.
//  FSM, 3 states, encoded in the package:
//   IDLE:  in_ready=0. On cfg_start with cfg_len!=0: acc=0, sat=0, cnt=cfg_len, go to ACCUM.
//          On cfg_start with cfg_len==0: acc=0, sat=0, go to DONE.
//   ACCUM: in_ready=1 (combinational from state). On each handshake:
//          acc = sat_add(acc, in_prod), cnt--. If cnt==1 on that handshake, go to DONE.
//          in_valid low: state is held, no change.
//   DONE:  out_valid=1. out_sum=acc and out_sat are stable while out_ready=0.
//          On out_ready: go to IDLE; out_valid=0 next cycle.
//  cfg_start outside IDLE is ignored, including in the cycle DONE->IDLE.
//  Earliest next start: the cycle after IDLE is re-entered.
//  Latency: out_valid rises 1 cycle after the last product handshake, or 1 cycle after
//  start when len=0.
//  Throughput: 1 product/cycle in ACCUM. Job overhead: 1 cycle start + 1 cycle drain.
//  Arithmetic: in_prod is zero-extended to ACC_W. The sum clamps at 2**ACC_W-1.
//  Any clamp sets out_sat, which holds until the next start. acc never wraps.
//  out_sum/out_sat hold their last values in IDLE. Outputs are registered; in_ready is not.
// CONFIGURATION
//  APPROX_BIAS_COMP_EN defined:
//   - each accepted product becomes in_prod+BIAS, computed at PROD_W+1 bits, before accumulation;
//   - this compensates the mean negative error of the truncating multiplier.
//  Not defined: BIAS is ignored and the sum is exact over the products received.
// STRUCTURE
//  Package approx_mac_pkg: state enum {IDLE, ACCUM, DONE}, default PROD_W, default ACC_W.
//  Sub-module approx_sat_add: parameterised ACC_W unsigned saturating adder.
//   - outputs sum and an overflow flag;
//   - combinational; its result is registered into acc here.
// TESTING
//  - ACC_W=24, len=3, products 100,200,300 -> out_sum=600, out_sat=0.
//    out_valid 1 cycle after the 3rd handshake.
//  - ACC_W=17, len=3, each product 65535 -> out_sum=131071, out_sat=1.
//  - len=0 start -> out_valid the next cycle, out_sum=0, out_sat=0, no in_ready pulse.
//  - Backpressure: in_valid toggled 1/0 with len=4 (sum 10) -> sum 10, 4 handshakes.
//    Then out_ready=0 for 5 cycles -> out_sum stable, in_ready=0, cfg_start ignored.
//  - rst=1 after 2 of 5 products -> next cycle IDLE, out_valid=0.
//    New job len=1, product 7 -> sum 7.
//  - BIAS=4, len=2, products 10,20 -> 38 with APPROX_BIAS_COMP_EN, 30 without.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// Shared types and default widths for the approximate MAC datapath.
package approx_mac_pkg;

  localparam int unsigned DEF_PROD_W = 16;
  localparam int unsigned DEF_ACC_W  = 24;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

endpackage

// File: rtl/approx_sat_add.sv
// Combinational unsigned saturating adder: acc + addend, clamped at 2**ACC_W-1.
module approx_sat_add #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned IN_W  = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_c_o,
  output logic             ovf_c_o
);

  // One guard bit above the wider operand so the raw sum never wraps.
  localparam int unsigned SUM_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

  logic [SUM_W-1:0] raw_sum;

  always_comb begin
    raw_sum = SUM_W'(acc_i) + SUM_W'(add_i);
    ovf_c_o = (raw_sum > ACC_MAX);
    sum_c_o = ovf_c_o ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/approx_dot_accumulator.sv
// Saturating dot-product accumulator fed by an approximate multiplier stream.
// Optional APPROX_BIAS_COMP_EN adds BIAS to every accepted product before accumulation.
module approx_dot_accumulator
  import approx_mac_pkg::*;
#(
  parameter int unsigned       PROD_W = DEF_PROD_W,
  parameter int unsigned       ACC_W  = DEF_ACC_W,
  parameter int unsigned       LEN_W  = DEF_LEN_W,
  parameter logic [PROD_W-1:0] BIAS   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              busy
);

`ifdef APPROX_BIAS_COMP_EN
  localparam int unsigned ADD_W = PROD_W + 1;
`else
  localparam int unsigned ADD_W = PROD_W;
`endif

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q;
  logic             busy_q;

  logic [ADD_W-1:0] addend;
  logic [ACC_W-1:0] sum_c;
  logic             ovf_c;

`ifdef APPROX_BIAS_COMP_EN
  // Offsets the mean negative error of the truncating multiplier; never wraps.
  assign addend = ADD_W'(in_prod) + ADD_W'(BIAS);
`else
  assign addend = in_prod;
  if (BIAS != '0) begin : g_bias_ignored
  end
`endif

  approx_sat_add #(
    .ACC_W (ACC_W),
    .IN_W  (ADD_W)
  ) u_sat_add (
    .acc_i   (acc_q),
    .add_i   (addend),
    .sum_c_o (sum_c),
    .ovf_c_o (ovf_c)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = cfg_len;
          state_d = (cfg_len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum_c;
          sat_d = sat_q | ovf_c;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Ready is a pure state decode so a product can land every cycle in ACCUM.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_sat   = sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Bench for approx_dot_accumulator: 24-bit and 17-bit instances share one stimulus stream.
module tb_approx_dot_accumulator;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned LEN_W  = 8;
  localparam logic [PROD_W-1:0] BIAS_V = 16'd4;
`ifdef APPROX_BIAS_COMP_EN
  localparam longint BIAS_EFF = 4;
`else
  localparam longint BIAS_EFF = 0;
`endif
  localparam longint MAX_A = 64'd16777215;
  localparam longint MAX_B = 64'd131071;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
  logic [23:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [16:0] out_sum_b;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  approx_dot_accumulator #(
    .PROD_W(PROD_W), .ACC_W(24), .LEN_W(LEN_W), .BIAS(BIAS_V)
  ) dut_a (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_sat(out_sat_a), .busy(busy_a)
  );

  approx_dot_accumulator #(
    .PROD_W(PROD_W), .ACC_W(17), .LEN_W(LEN_W), .BIAS(BIAS_V)
  ) dut_b (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_sat(out_sat_b), .busy(busy_b)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] clamp(input longint total, input longint mx);
    return (total > mx) ? mx : total;
  endfunction

  // Reference: job phase (0 idle, 1 collecting, 2 result held), products left, exact running total.
  int     m_st    = 0;
  int     m_left  = 0;
  longint m_total = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st    = 0;
      m_left  = 0;
      m_total = 0;
    end else begin
      case (m_st)
        0: if (cfg_start) begin
          m_total = 0;
          m_left  = int'(cfg_len);
          m_st    = (cfg_len == '0) ? 2 : 1;
        end
        1: if (in_valid) begin
          m_total = m_total + longint'(in_prod) + BIAS_EFF;
          m_left  = m_left - 1;
          if (m_left == 0) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready_a",  64'(in_ready_a),  64'(m_st == 1));
      check("out_valid_a", 64'(out_valid_a), 64'(m_st == 2));
      check("busy_a",      64'(busy_a),      64'(m_st != 0));
      check("out_sum_a",   64'(out_sum_a),   clamp(m_total, MAX_A));
      check("out_sat_a",   64'(out_sat_a),   64'(m_total > MAX_A));
      check("in_ready_b",  64'(in_ready_b),  64'(m_st == 1));
      check("out_valid_b", 64'(out_valid_b), 64'(m_st == 2));
      check("out_sum_b",   64'(out_sum_b),   clamp(m_total, MAX_B));
      check("out_sat_b",   64'(out_sat_b),   64'(m_total > MAX_B));
      if (in_valid && in_ready_a) hs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    cfg_start = 1'b1;
    cfg_len   = LEN_W'(len);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int p);
    in_valid = 1'b1;
    in_prod  = PROD_W'(p);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0;
    in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_busy",      64'(busy_a),      64'd0);
    check("rst_in_ready",  64'(in_ready_a),  64'd0);
    check("rst_out_sum",   64'(out_sum_a),   64'd0);
    check("rst_out_sat",   64'(out_sat_a),   64'd0);
    rst = 1'b0;

    // 100+200+300, result one cycle after the last handshake
    start_job(3);
    feed(100);
    feed(200);
    check("lat_pre_valid", 64'(out_valid_a), 64'd0);
    feed(300);
    check("lat_valid",   64'(out_valid_a), 64'd1);
    check("sum600_a",    64'(out_sum_a),   64'(600 + 3 * BIAS_EFF));
    check("sum600_sat",  64'(out_sat_a),   64'd0);
    drain();

    // three full-scale products clamp the 17-bit instance only
    start_job(3);
    repeat (3) feed(65535);
    check("big_sum_b", 64'(out_sum_b), 64'd131071);
    check("big_sat_b", 64'(out_sat_b), 64'd1);
    check("big_sum_a", 64'(out_sum_a), 64'(196605 + 3 * BIAS_EFF));
    check("big_sat_a", 64'(out_sat_a), 64'd0);
    drain();

    // empty job
    start_job(0);
    check("len0_valid",   64'(out_valid_a), 64'd1);
    check("len0_sum",     64'(out_sum_b),   64'd0);
    check("len0_sat",     64'(out_sat_b),   64'd0);
    check("len0_inready", 64'(in_ready_a),  64'd0);
    drain();

    // toggled in_valid, then held result with stray starts
    h0 = hs_cnt;
    start_job(4);
    for (int i = 1; i <= 4; i++) begin
      feed(i);
      tick();
    end
    check("bp_handshakes", 64'(hs_cnt - h0), 64'd4);
    check("bp_sum",        64'(out_sum_a),   64'(10 + 4 * BIAS_EFF));
    cfg_start = 1'b1;
    cfg_len   = LEN_W'(2);
    repeat (5) begin
      tick();
      check("hold_sum",     64'(out_sum_a),   64'(10 + 4 * BIAS_EFF));
      check("hold_valid",   64'(out_valid_a), 64'd1);
      check("hold_inready", 64'(in_ready_a),  64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cfg_start = 1'b0;
    check("exit_idle_busy", 64'(busy_a), 64'd0);
    tick();
    check("start_ignored_busy", 64'(busy_a), 64'd0);

    // reset mid-job drops the job
    start_job(5);
    feed(9);
    feed(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid_a), 64'd0);
    check("midrst_busy",  64'(busy_a),      64'd0);
    check("midrst_sum",   64'(out_sum_a),   64'd0);
    start_job(1);
    feed(7);
    check("after_rst_sum", 64'(out_sum_a), 64'(7 + BIAS_EFF));
    drain();

    // bias compensation
    start_job(2);
    feed(10);
    feed(20);
`ifdef APPROX_BIAS_COMP_EN
    check("bias_sum", 64'(out_sum_a), 64'd38);
`else
    check("bias_sum", 64'(out_sum_a), 64'd30);
`endif
    drain();

    // random traffic: starts, lengths, valid/ready, occasional reset
    for (int c = 0; c < 6000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cfg_start = ($urandom_range(0, 3) == 0);
      cfg_len   = ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(0, 255))
                                              : LEN_W'($urandom_range(0, 6));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_prod   = ($urandom_range(0, 1) == 1) ? 16'hFFFF - PROD_W'($urandom_range(0, 255))
                                              : PROD_W'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
